// File: rtl/tile_stdio_axi_writer_if.sv
// -----------------------------------------------------------------------------
// tile_stdio_axi_writer_if
//   AXI4 write-channel bundle (AW, W, B) between the tile print/EOC writer and
//   the tile data_out port.
//   master : driven by the writer (AW/W payload and valid, B ready)
//   slave  : driven by the interconnect or bench (AW/W ready, B valid/resp)
// -----------------------------------------------------------------------------
interface tile_stdio_axi_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic                aw_valid;
  logic [ADDR_W-1:0]   aw_addr;
  logic [ID_W-1:0]     aw_id;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_ready;

  logic                w_valid;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_ready;

  logic                b_valid;
  logic [1:0]          b_resp;
  logic                b_ready;

  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready
  );
endinterface

// File: rtl/tile_stdio_axi_writer.sv
// -----------------------------------------------------------------------------
// tile_stdio_axi_writer
//   Tile-side initiator for the simulation print / end-of-computation channel.
//   Characters from the core are queued in a small FIFO and each one becomes a
//   single-beat AXI write to STDOUT_ADDR. A single exit request produces an
//   optional exit-code write to STDERR_ADDR (non-zero codes only) followed by
//   the EOC word write; after that the block back-pressures everything until
//   reset. Only one write is ever outstanding.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   chr_valid_i/chr_data_i/chr_ready_o    character request (0x00 is dropped)
//   exit_valid_i/exit_code_i/exit_ready_o exit request (accepted once)
//   axi                          AXI4 AW/W/B master port
//   busy_o                       FIFO non-empty or FSM not idle
//   done_o                       sticky, EOC write completed
//   err_o                        sticky, some B response was not OKAY
//   chr_cnt_o                    characters acknowledged OKAY, wraps at 2^32
// -----------------------------------------------------------------------------
module tile_stdio_axi_writer #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                ID_W        = 4,
  parameter int                FIFO_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = ADDR_W'(32'h5FFF_0004),
  parameter logic [ADDR_W-1:0] STDERR_ADDR = ADDR_W'(32'h5FFF_0000),
  parameter logic [ADDR_W-1:0] EOC_ADDR    = ADDR_W'(32'h5C03_0000)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           chr_valid_i,
  input  logic [7:0]                     chr_data_i,
  output logic                           chr_ready_o,
  input  logic                           exit_valid_i,
  input  logic [7:0]                     exit_code_i,
  output logic                           exit_ready_o,
  tile_stdio_axi_writer_if.master        axi,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [31:0]                    chr_cnt_o
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [2:0]  AXI_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [1:0]  RESP_OK  = 2'b00;

  typedef enum logic [1:0] {IDLE_S, ADDR_S, RESP_S} state_e;
  typedef enum logic [1:0] {WR_CHR, WR_ERR, WR_EOC} wr_kind_e;

  state_e              state_q, state_d;
  wr_kind_e            wr_kind_q, wr_kind_d;
  logic [7:0]          fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                exit_pend_q, exit_pend_d;
  logic [7:0]          exit_code_q, exit_code_d;
  logic                stderr_sent_q, stderr_sent_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [31:0]         chr_cnt_q, chr_cnt_d;
  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                b_ready_q, b_ready_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;

  logic fifo_empty, fifo_full;
  logic push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  // Ready is forced low while reset is held so the core sees no acceptance
  // during a mid-transaction reset.
  assign chr_ready_o  = !rst_i && !fifo_full && !exit_pend_q && !done_q;
  assign exit_ready_o = !rst_i && !exit_pend_q && !done_q;

  // NOTE: every signal written here gets its default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    wr_kind_d     = wr_kind_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    exit_pend_d   = exit_pend_q;
    exit_code_d   = exit_code_q;
    stderr_sent_d = stderr_sent_q;
    done_d        = done_q;
    err_d         = err_q;
    chr_cnt_d     = chr_cnt_q;
    aw_valid_d    = aw_valid_q;
    w_valid_d     = w_valid_q;
    b_ready_d     = b_ready_q;
    aw_addr_d     = aw_addr_q;
    w_data_d      = w_data_q;
    pop           = 1'b0;

    // NUL characters are acknowledged to the core but never reach the bus.
    push = chr_valid_i && chr_ready_o && (chr_data_i != 8'h00);

    if (exit_valid_i && exit_ready_o) begin
      exit_pend_d = 1'b1;
      exit_code_d = exit_code_i;
    end

    case (state_q)
      IDLE_S: begin
        // Queued characters always go before the exit sequence, which also
        // orders a same-cycle char+exit pair correctly.
        if (!fifo_empty) begin
          pop        = 1'b1;
          wr_kind_d  = WR_CHR;
          aw_addr_d  = STDOUT_ADDR;
          w_data_d   = DATA_W'(fifo_mem_q[rd_ptr_q]);
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = ADDR_S;
        end else if (exit_pend_q) begin
          if (exit_code_q != 8'h00 && !stderr_sent_q) begin
            wr_kind_d = WR_ERR;
            aw_addr_d = STDERR_ADDR;
            w_data_d  = DATA_W'(exit_code_q);
          end else begin
            wr_kind_d = WR_EOC;
            aw_addr_d = EOC_ADDR;
            w_data_d  = DATA_W'({8'h80, 16'h0000, exit_code_q});
          end
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = ADDR_S;
        end
      end

      ADDR_S: begin
        // AW and W complete independently; wait until both are done.
        if (axi.aw_ready) aw_valid_d = 1'b0;
        if (axi.w_ready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = RESP_S;
        end
      end

      RESP_S: begin
        if (axi.b_valid) begin
          b_ready_d = 1'b0;
          state_d   = IDLE_S;
          if (axi.b_resp != RESP_OK) err_d = 1'b1;
          case (wr_kind_q)
            WR_CHR: if (axi.b_resp == RESP_OK) chr_cnt_d = chr_cnt_q + 32'd1;
            WR_ERR: stderr_sent_d = 1'b1;
            WR_EOC: begin
              exit_pend_d = 1'b0;
              done_d      = 1'b1;
            end
            default: ;
          endcase
        end
      end

      default: state_d = IDLE_S;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE_S;
      wr_kind_q     <= WR_CHR;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      exit_pend_q   <= 1'b0;
      exit_code_q   <= 8'h00;
      stderr_sent_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      chr_cnt_q     <= 32'd0;
      aw_valid_q    <= 1'b0;
      w_valid_q     <= 1'b0;
      b_ready_q     <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_kind_q     <= wr_kind_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      exit_pend_q   <= exit_pend_d;
      exit_code_q   <= exit_code_d;
      stderr_sent_q <= stderr_sent_d;
      done_q        <= done_d;
      err_q         <= err_d;
      chr_cnt_q     <= chr_cnt_d;
      aw_valid_q    <= aw_valid_d;
      w_valid_q     <= w_valid_d;
      b_ready_q     <= b_ready_d;
      aw_addr_q     <= aw_addr_d;
      w_data_q      <= w_data_d;
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only read after it has been
  // written, and the pointers/count (which are reset) guard that.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= chr_data_i;
  end

  assign axi.aw_valid = aw_valid_q;
  assign axi.aw_addr  = aw_addr_q;
  assign axi.aw_id    = {ID_W{1'b0}};
  assign axi.aw_len   = 8'd0;
  assign axi.aw_size  = AXI_SIZE;
  assign axi.aw_burst = 2'b01;
  assign axi.w_valid  = w_valid_q;
  assign axi.w_data   = w_data_q;
  assign axi.w_strb   = '1;
  assign axi.w_last   = 1'b1;
  assign axi.b_ready  = b_ready_q;

  assign busy_o    = !fifo_empty || (state_q != IDLE_S);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign chr_cnt_o = chr_cnt_q;

  // A write response may only arrive while the write is waiting for it.
  b_only_in_resp_a: assert property (@(posedge clk_i) disable iff (rst_i)
    axi.b_valid |-> (state_q == RESP_S));

endmodule

// File: tb/tb_tile_stdio_axi_writer.sv
module tb_tile_stdio_axi_writer;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam logic [31:0] STDOUT_A = 32'h5FFF_0004;
  localparam logic [31:0] STDERR_A = 32'h5FFF_0000;
  localparam logic [31:0] EOC_A    = 32'h5C03_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chr_valid = 1'b0;
  logic [7:0]  chr_data = 8'h00;
  logic        chr_ready;
  logic        exit_valid = 1'b0;
  logic [7:0]  exit_code = 8'h00;
  logic        exit_ready;
  logic        busy, done, err;
  logic [31:0] chr_cnt;

  always #5 clk = ~clk;

  tile_stdio_axi_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  tile_stdio_axi_writer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .chr_valid_i  (chr_valid),
    .chr_data_i   (chr_data),
    .chr_ready_o  (chr_ready),
    .exit_valid_i (exit_valid),
    .exit_code_i  (exit_code),
    .exit_ready_o (exit_ready),
    .axi          (axi),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .chr_cnt_o    (chr_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected write sequence built from accepted requests.
  wr_t        exp_q[$];
  wr_t        obs_q[$];
  logic [1:0] resp_log[$];

  // Slave knobs
  int aw_pct = 100, w_pct = 100, b_dly_max = 0, err_pct = 0, err_idx = -1, aw_delay = 0;
  bit aw_hold = 1'b0;

  // Slave state
  bit          aw_got, w_got, b_act, aw_pend, w_pend;
  int          b_cnt, wr_idx, aw_vcyc, last_aw_vcyc;
  logic [31:0] cur_addr, cur_data, aw_prev_addr, w_prev_data;
  logic [1:0]  cur_resp;

  // AXI slave: all decisions at the negedge apply to the following posedge.
  initial begin : axi_slave
    bit rdy;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b00;
        aw_got = 0; w_got = 0; b_act = 0; aw_pend = 0; w_pend = 0;
        b_cnt = 0; wr_idx = 0; aw_vcyc = 0;
      end else begin
        axi.b_valid = 1'b0;
        if (aw_got && w_got && !b_act) begin
          b_act = 1;
          b_cnt = int'($urandom_range(b_dly_max, 0));
          if (wr_idx == err_idx) cur_resp = 2'b10;
          else if ($urandom_range(99, 0) < err_pct) cur_resp = 2'($urandom_range(3, 1));
          else cur_resp = 2'b00;
        end
        if (b_act) begin
          if (b_cnt > 0) b_cnt--;
          else begin
            axi.b_valid = 1'b1;
            axi.b_resp  = cur_resp;
            if (axi.b_ready) begin
              obs_q.push_back('{addr: cur_addr, data: cur_data});
              resp_log.push_back(cur_resp);
              aw_got = 0; w_got = 0; b_act = 0; wr_idx++;
            end
          end
        end

        axi.aw_ready = 1'b0;
        if (axi.aw_valid) begin
          check("aw_single_outstanding", 64'(aw_got || b_act), 64'(0));
          if (aw_pend) check("aw_addr_stable", 64'(axi.aw_addr), 64'(aw_prev_addr));
          aw_vcyc++;
          rdy = !aw_hold && (aw_vcyc > aw_delay) && ($urandom_range(99, 0) < aw_pct);
          axi.aw_ready = rdy;
          if (rdy) begin
            cur_addr = axi.aw_addr; aw_got = 1; aw_pend = 0;
            last_aw_vcyc = aw_vcyc; aw_vcyc = 0;
            check("aw_attr", 64'({axi.aw_id, axi.aw_len, axi.aw_size, axi.aw_burst}),
                  64'({4'h0, 8'h00, 3'd2, 2'b01}));
          end else begin
            aw_pend = 1; aw_prev_addr = axi.aw_addr;
          end
        end

        axi.w_ready = 1'b0;
        if (axi.w_valid) begin
          check("w_single_beat", 64'(w_got || b_act), 64'(0));
          if (w_pend) check("w_data_stable", 64'(axi.w_data), 64'(w_prev_data));
          rdy = ($urandom_range(99, 0) < w_pct);
          axi.w_ready = rdy;
          if (rdy) begin
            cur_data = axi.w_data; w_got = 1; w_pend = 0;
            check("w_attr", 64'({axi.w_strb, axi.w_last}), 64'({4'hF, 1'b1}));
          end else begin
            w_pend = 1; w_prev_data = axi.w_data;
          end
        end
      end
    end
  end

  task automatic model_chr(input logic [7:0] c);
    if (c != 8'h00) exp_q.push_back('{addr: STDOUT_A, data: {24'h0, c}});
  endtask

  task automatic model_exit(input logic [7:0] code);
    if (code != 8'h00) exp_q.push_back('{addr: STDERR_A, data: {24'h0, code}});
    exp_q.push_back('{addr: EOC_A, data: 32'h8000_0000 | {24'h0, code}});
  endtask

  task automatic wait_chr_ready();
    int t = 0;
    while (!chr_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("chr_ready_timeout", 64'(chr_ready), 64'(1));
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic push_chr(input logic [7:0] c);
    chr_valid = 1'b1; chr_data = c;
    wait_chr_ready();
    @(negedge clk);
    chr_valid = 1'b0;
    model_chr(c);
  endtask

  task automatic push_exit(input logic [7:0] code);
    int t = 0;
    exit_valid = 1'b1; exit_code = code;
    while (!exit_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("exit_ready_timeout", 64'(exit_ready), 64'(1));
    @(negedge clk);
    exit_valid = 1'b0;
    model_exit(code);
  endtask

  task automatic push_both(input logic [7:0] c, input logic [7:0] code);
    wait_chr_ready();
    chr_valid = 1'b1; chr_data = c; exit_valid = 1'b1; exit_code = code;
    @(negedge clk);
    chr_valid = 1'b0; exit_valid = 1'b0;
    model_chr(c);
    model_exit(code);
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while ((obs_q.size() < n || busy) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) check("drain_timeout", 64'(obs_q.size()), 64'(n));
    repeat (12) @(negedge clk);
  endtask

  task automatic compare(input string name, input bit exp_done);
    int ecnt = 0;
    bit eerr = 1'b0;
    check({name, "/num_writes"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s/addr%0d", name, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s/data%0d", name, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
      if (resp_log[i] != 2'b00) eerr = 1'b1;
      else if (exp_q[i].addr == STDOUT_A) ecnt++;
    end
    check({name, "/chr_cnt"}, 64'(chr_cnt), 64'(ecnt));
    check({name, "/err"}, 64'(err), 64'(eerr));
    check({name, "/done"}, 64'(done), 64'(exp_done));
    check({name, "/busy"}, 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1; chr_valid = 1'b0; exit_valid = 1'b0;
    aw_hold = 1'b0; aw_pct = 100; w_pct = 100; b_dly_max = 0;
    err_pct = 0; err_idx = -1; aw_delay = 0;
    repeat (2) @(negedge clk);
    obs_q.delete(); exp_q.delete(); resp_log.delete();
    check("rst_outputs", 64'({axi.aw_valid, axi.w_valid, axi.b_ready, chr_ready,
                              exit_ready, busy, done, err}), 64'(0));
    check("rst_chr_cnt", 64'(chr_cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'({chr_ready, exit_ready}), 64'(2'b11));
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] c, code;
    int n, mode;

    // "Hi\n" with all readies high
    do_reset();
    push_chr(8'h48); push_chr(8'h69); push_chr(8'h0A);
    wait_writes(3);
    compare("hi", 1'b0);

    // AW ready delayed three cycles, W immediate
    do_reset();
    aw_delay = 3;
    push_chr(8'h78);
    wait_writes(1);
    check("aw_valid_cycles", 64'(last_aw_vcyc), 64'(4));
    compare("aw_delay", 1'b0);

    // Nine characters against a stalled AW channel
    do_reset();
    aw_hold = 1'b1;
    for (int i = 0; i < 9; i++) push_chr(8'h61 + 8'(i));
    check("full_backpressure", 64'(chr_ready), 64'(0));
    repeat (5) @(negedge clk);
    check("no_write_while_stalled", 64'(obs_q.size()), 64'(0));
    aw_hold = 1'b0;
    wait_writes(9);
    compare("fill9", 1'b0);

    // 'A' then exit code 5
    do_reset();
    push_chr(8'h41);
    push_exit(8'd5);
    wait_writes(3);
    compare("exit5", 1'b1);
    check("done_backpressure", 64'({chr_ready, exit_ready}), 64'(0));

    // NUL char dropped, exit code 0 only writes EOC
    do_reset();
    push_chr(8'h00);
    repeat (6) @(negedge clk);
    check("nul_no_write", 64'(obs_q.size()), 64'(0));
    check("nul_busy", 64'(busy), 64'(0));
    push_exit(8'h00);
    wait_writes(1);
    compare("exit0", 1'b1);

    // SLVERR on the second character, err stays sticky
    do_reset();
    err_idx = 1;
    push_chr(8'h70); push_chr(8'h71);
    wait_writes(2);
    compare("slverr", 1'b0);
    push_chr(8'h72);
    wait_writes(3);
    compare("slverr_sticky", 1'b0);

    // Reset asserted while a write is in ADDR
    do_reset();
    aw_hold = 1'b1;
    push_chr(8'h5A);
    n = 0;
    while (!axi.aw_valid && n < 50) begin @(negedge clk); n++; end
    check("mid_rst_aw_valid_seen", 64'(axi.aw_valid), 64'(1));
    #3 rst = 1'b1;
    #1;
    check("mid_rst_outputs", 64'({axi.aw_valid, axi.w_valid, axi.b_ready, chr_ready,
                                  exit_ready, busy, done, err}), 64'(0));
    check("mid_rst_chr_cnt", 64'(chr_cnt), 64'(0));

    // Randomized scenarios
    for (int s = 0; s < 20; s++) begin
      do_reset();
      aw_pct    = int'($urandom_range(100, 30));
      w_pct     = int'($urandom_range(100, 30));
      b_dly_max = int'($urandom_range(3, 0));
      err_pct   = (s % 3 == 0) ? 25 : 0;
      n    = int'($urandom_range(10, 0));
      mode = int'($urandom_range(2, 0));
      code = ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      for (int i = 0; i < n; i++) begin
        c = ($urandom_range(9, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
        if (mode == 2 && i == n - 1) push_both(c, code);
        else push_chr(c);
        if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      if (mode == 1 || (mode == 2 && n == 0)) push_exit(code);
      wait_writes(exp_q.size());
      compare($sformatf("rand%0d", s), mode != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
